// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin one bit per cycle,
// LSB first, and presents the registered difference and borrow-out with a
// one-cycle done pulse. Fixed latency; start is only honoured in IDLE.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               d_c;
  logic               br_next_c;
  logic [WIDTH-1:0]   res_next_c;
  logic               last_bit_c;

  // One-bit full-subtractor slice on the current LSBs plus running borrow
  always_comb begin
    d_c        = a_q[0] ^ b_q[0] ^ br_q;
    br_next_c  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_next_c = {d_c, res_q[WIDTH-1:1]};
    last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_next_c;
          res_q <= res_next_c;
          if (last_bit_c) begin
            diff    <= res_next_c;
            borrow  <= br_next_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for directed,
// random, re-pulse and reset-abort cases, and a 3-bit instance swept
// exhaustively with start held high.
module tb_serial_subtractor;

  logic       clk;
  int         n_checks;
  int         n_fail;

  // 8-bit instance
  logic       rst_n8, start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic [7:0] prev_diff8;
  logic       prev_borrow8;

  // 3-bit instance
  logic       rst_n3, start3, bin3;
  logic [2:0] a3, b3;
  logic       busy3, done3, borrow3;
  logic [2:0] diff3;
  logic [3:0] exp3_q[$];
  int         cycle3;
  int         last_done3;
  int         ndone3;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned integer subtraction, borrow from integer comparison
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    int   r;
    logic bw;
    r  = int'(x) - int'(y) - int'(bi);
    bw = (int'(x) < int'(y) + int'(bi));
    return {bw, 8'(r)};
  endfunction

  function automatic logic [3:0] model3(input logic [2:0] x, input logic [2:0] y, input logic bi);
    int   r;
    logic bw;
    r  = int'(x) - int'(y) - int'(bi);
    bw = (int'(x) < int'(y) + int'(bi));
    return {bw, 3'(r)};
  endfunction

  // Full 8-bit operation; optionally re-pulse start with junk during SHIFT and DONE
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi, input bit repulse);
    logic [8:0] e;
    e = model8(x, y, bi);
    @(negedge clk);
    a8 = x; b8 = y; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("busy8_shift", busy8, 1'b1);
      check("done8_shift", done8, 1'b0);
      check("diff8_hold", diff8, prev_diff8);
      check("borrow8_hold", borrow8, prev_borrow8);
      if (repulse) begin
        start8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      @(negedge clk);
    end
    check("busy8_done", busy8, 1'b0);
    check("done8_pulse", done8, 1'b1);
    check("diff8", diff8, e[7:0]);
    check("borrow8", borrow8, e[8]);
    prev_diff8   = e[7:0];
    prev_borrow8 = e[8];
    @(negedge clk);
    start8 = 1'b0;
    check("done8_one_cycle", done8, 1'b0);
    check("busy8_idle", busy8, 1'b0);
    @(negedge clk);
    check("busy8_no_restart", busy8, 1'b0);
    check("diff8_after", diff8, prev_diff8);
  endtask

  // Monitor for the 3-bit instance: results in order, pulses 5 cycles apart
  always @(negedge clk) begin
    logic [3:0] e;
    cycle3++;
    if (done3) begin
      ndone3++;
      if (exp3_q.size() == 0) begin
        check("done3_unexpected", done3, 1'b0);
      end else begin
        e = exp3_q.pop_front();
        check("res3", {borrow3, diff3}, e);
      end
      if (last_done3 >= 0)
        check("done3_spacing", 64'(cycle3 - last_done3), 64'd5);
      last_done3 = cycle3;
    end
  end

  initial begin
    int guard;
    n_checks = 0; n_fail = 0;
    cycle3 = 0; last_done3 = -1; ndone3 = 0;
    rst_n8 = 1'b0; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
    rst_n3 = 1'b0; start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    prev_diff8 = '0; prev_borrow8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset dominates a held start
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_diff8", diff8, 8'h00);
    check("rst_borrow8", borrow8, 1'b0);
    start8 = 1'b0;
    rst_n8 = 1'b1;

    // Directed cases
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    check("dir_5a_3c", {borrow8, diff8}, 9'h01E);
    op8(8'h00, 8'h01, 1'b0, 1'b0);
    check("dir_00_01", {borrow8, diff8}, 9'h1FF);
    op8(8'h10, 8'h10, 1'b1, 1'b0);
    check("dir_10_10_1", {borrow8, diff8}, 9'h1FF);
    op8(8'hFF, 8'h00, 1'b1, 1'b0);
    check("dir_ff_00_1", {borrow8, diff8}, 9'h0FE);

    // Start re-pulsed during SHIFT and DONE is ignored
    op8(8'h5A, 8'h3C, 1'b0, 1'b1);
    op8(8'h01, 8'hFE, 1'b1, 1'b1);

    // Random operations
    for (int i = 0; i < 24; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

    // Reset after bit 3 aborts the operation
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h17; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n8 = 1'b0;
    @(negedge clk);
    rst_n8 = 1'b1;
    check("abort_busy8", busy8, 1'b0);
    check("abort_done8", done8, 1'b0);
    check("abort_diff8", diff8, 8'h00);
    check("abort_borrow8", borrow8, 1'b0);
    prev_diff8 = 8'h00; prev_borrow8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done8", done8, 1'b0);
    end
    op8(8'h3C, 8'h5A, 1'b0, 1'b0);

    // 3-bit exhaustive sweep, start held high from release of reset
    a3 = 3'd0; b3 = 3'd0; bin3 = 1'b0; start3 = 1'b1;
    @(negedge clk);
    rst_n3 = 1'b1;
    for (int k = 0; k < 128; k++) begin
      a3   = 3'(k >> 4);
      b3   = 3'(k >> 1);
      bin3 = 1'(k);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!busy3 && guard < 10);
      if (k == 0) check("first_start3_latency", 64'(guard), 64'd1);
      check("busy3_rise", busy3, 1'b1);
      exp3_q.push_back(model3(a3, b3, bin3));
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (busy3 && guard < 10);
      check("busy3_len", 64'(guard), 64'd3);
    end
    guard = 0;
    while (exp3_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    start3 = 1'b0;
    check("queue3_drained", 64'(exp3_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    check("done3_count", 64'(ndone3), 64'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
